// File: rtl/spiker_reader.sv
// spiker_reader
//   Stages a spike frame written word-by-word from the register file, then on
//   start_i snapshots it into a shadow buffer and presents it to the core for
//   N_STEPS ready/valid handshakes, with a one-cycle gap between timesteps.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   test_mode_i     test-mode tie, functionally unused
//   reg_we_i        word write strobe (accepted only while not busy)
//   reg_widx_i      word index, valid range 0..N_REG-1
//   reg_wdata_i     word data
//   start_i         inference start pulse (accepted only while not busy)
//   ip_ready_i      core ready for a spike vector
//   spikes_o        shadow frame bits [N_SPIKES-1:0]
//   spikes_valid_o  spikes_o valid (DRIVE state)
//   sample_o        one-cycle pulse after each accepted vector
//   busy_o          inference in progress (DRIVE or GAP)
//   done_o          inference finished, held until the next start
//   err_o           sticky error: bad index, or write/start while busy
module spiker_reader #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SPIKES = 784,
    parameter int unsigned N_REG    = 25,
    parameter int unsigned N_STEPS  = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_mode_i,
    input  logic                     reg_we_i,
    input  logic [$clog2(N_REG)-1:0] reg_widx_i,
    input  logic [WIDTH-1:0]         reg_wdata_i,
    input  logic                     start_i,
    input  logic                     ip_ready_i,
    output logic [N_SPIKES-1:0]      spikes_o,
    output logic                     spikes_valid_o,
    output logic                     sample_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned IDX_W   = $clog2(N_REG);
    localparam int unsigned IDXP_W  = IDX_W + 1;
    localparam int unsigned CNT_W   = $clog2(N_STEPS) + 1;
    localparam int unsigned FRAME_W = N_REG * WIDTH;

    localparam logic [IDX_W:0]   N_REG_L   = IDXP_W'(N_REG);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [WIDTH-1:0] stage_q  [N_REG];
    logic [WIDTH-1:0] shadow_q [N_REG];
    logic             sample_q;
    logic             err_q;

    logic             busy;
    logic             start_ok;
    logic             wr_in_range;
    logic             wr_ok;
    logic             err_set;
    logic             handshake;
    logic [FRAME_W-1:0] frame_flat;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    assign busy        = (state_q == S_DRIVE) || (state_q == S_GAP);
    assign start_ok    = start_i && !busy;
    assign wr_in_range = {1'b0, reg_widx_i} < N_REG_L;
    assign wr_ok       = reg_we_i && wr_in_range && !busy;
    assign err_set     = (reg_we_i && (!wr_in_range || busy)) || (start_i && busy);
    assign handshake   = (state_q == S_DRIVE) && ip_ready_i;

    // Next-state logic; ip_ready_i is only looked at in DRIVE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_DRIVE;
                    step_d  = '0;
                end
            end
            S_DRIVE: begin
                if (ip_ready_i) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + CNT_W'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_DRIVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            sample_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            sample_q <= handshake;
            // A new error in the same cycle as an accepted start wins.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (start_ok) begin
                err_q <= 1'b0;
            end
        end
    end

    // Staging and shadow buffers. The shadow takes the staging contents as
    // they were before any write landing on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < N_REG; k++) begin
                stage_q[k]  <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REG; k++) begin
                if (wr_ok && (reg_widx_i == IDX_W'(k))) begin
                    stage_q[k] <= reg_wdata_i;
                end
                if (start_ok) begin
                    shadow_q[k] <= stage_q[k];
                end
            end
        end
    end

    always_comb begin
        frame_flat = '0;
        for (int unsigned k = 0; k < N_REG; k++) begin
            frame_flat[k*WIDTH +: WIDTH] = shadow_q[k];
        end
    end

    if (FRAME_W > N_SPIKES) begin : g_excess
        logic [FRAME_W-N_SPIKES-1:0] unused_frame_hi;
        assign unused_frame_hi = frame_flat[FRAME_W-1:N_SPIKES];
    end

    assign spikes_o       = frame_flat[N_SPIKES-1:0];
    assign spikes_valid_o = (state_q == S_DRIVE);
    assign sample_o       = sample_q;
    assign busy_o         = busy;
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_spiker_reader.sv
module tb_spiker_reader;

    localparam int W   = 32;
    localparam int NS  = 784;
    localparam int NR  = 25;
    localparam int NST = 15;
    localparam int IW  = $clog2(NR);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          test_mode_i;
    logic          reg_we_i;
    logic [IW-1:0] reg_widx_i;
    logic [W-1:0]  reg_wdata_i;
    logic          start_i;
    logic          ip_ready_i;
    logic [NS-1:0] spikes_o;
    logic          spikes_valid_o;
    logic          sample_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    spiker_reader #(
        .WIDTH    (W),
        .N_SPIKES (NS),
        .N_REG    (NR),
        .N_STEPS  (NST)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_mode_i    (test_mode_i),
        .reg_we_i       (reg_we_i),
        .reg_widx_i     (reg_widx_i),
        .reg_wdata_i    (reg_wdata_i),
        .start_i        (start_i),
        .ip_ready_i     (ip_ready_i),
        .spikes_o       (spikes_o),
        .spikes_valid_o (spikes_valid_o),
        .sample_o       (sample_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  m_stage [NR];
    bit            exp_err;
    logic [NS-1:0] sb_q [$];

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        bit            exp_err;
        bit            rnd;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [NS-1:0] frame_of();
        logic [NR*W-1:0] f;
        for (int k = 0; k < NR; k++) f[k*W +: W] = m_stage[k];
        return f[NS-1:0];
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NR; k++) m_stage[k] = '0;
        exp_err = 1'b0;
        sb_q.delete();
    endtask

    // Write while idle/done; call right after a falling edge.
    task automatic wr(input logic [IW-1:0] idx, input logic [W-1:0] data);
        reg_we_i    = 1'b1;
        reg_widx_i  = idx;
        reg_wdata_i = data;
        if (int'(idx) < NR) m_stage[idx] = data;
        else exp_err = 1'b1;
        @(negedge clk_i);
        reg_we_i = 1'b0;
    endtask

    // One inference with optional stall, busy write, busy start, reset hooks.
    task automatic run_inf(input bit rnd, input int stall_step, input int stall_len,
                           input int bw_step, input int sb_step, input int rst_step,
                           input bit same_wr, output int lat);
        int cyc, first_v, hs_n, stall_ctr;
        bit hs_prev, bw_done, sb_done, exp_done;
        logic [NS-1:0] fr;
        fr = frame_of();
        for (int i = 0; i < NST; i++) sb_q.push_back(fr);
        start_i    = 1'b1;
        ip_ready_i = 1'b1;
        exp_err    = 1'b0;
        if (same_wr) begin
            reg_we_i    = 1'b1;
            reg_widx_i  = '0;
            reg_wdata_i = 32'h1;
            m_stage[0]  = 32'h1;
        end
        cyc = 0; first_v = -1; hs_n = 0; stall_ctr = 0; lat = -1;
        hs_prev = 0; bw_done = 0; sb_done = 0;
        while (1) begin
            @(negedge clk_i);
            cyc++;
            start_i  = 1'b0;
            reg_we_i = 1'b0;
            exp_done = (hs_n == NST);
            chk("sample", 32'(sample_o), 32'(hs_prev));
            chk("err", 32'(err_o), 32'(exp_err));
            chk("busy", 32'(busy_o), 32'(!exp_done));
            chk("done", 32'(done_o), 32'(exp_done));
            if (cyc == 1) chk("valid_latency", 32'(spikes_valid_o), 32'd1);
            if (hs_prev && !exp_done) chk("gap_valid", 32'(spikes_valid_o), 32'd0);
            if (spikes_valid_o && first_v < 0) first_v = cyc;
            if (exp_done) begin
                lat = cyc - first_v;
                break;
            end
            if (cyc > 2000) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout: handshakes %0d want %0d", hs_n, NST);
                break;
            end
            if (rst_step == hs_n && spikes_valid_o) begin
                rst_ni = 1'b0;
                #1;
                chkv("rst_spikes", spikes_o, '0);
                chk("rst_valid", 32'(spikes_valid_o), 32'd0);
                chk("rst_sample", 32'(sample_o), 32'd0);
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_done", 32'(done_o), 32'd0);
                chk("rst_err", 32'(err_o), 32'd0);
                clear_model();
                ip_ready_i = 1'b0;
                @(negedge clk_i);
                rst_ni = 1'b1;
                return;
            end
            if (stall_step == hs_n && spikes_valid_o && stall_ctr < stall_len) begin
                ip_ready_i = 1'b0;
                stall_ctr++;
            end else begin
                ip_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bw_step == hs_n && spikes_valid_o && !bw_done) begin
                reg_we_i    = 1'b1;
                reg_widx_i  = IW'(3);
                reg_wdata_i = 32'hFFFF_FFFF;
                exp_err     = 1'b1;
                bw_done     = 1;
            end
            if (sb_step == hs_n && spikes_valid_o && !sb_done) begin
                start_i = 1'b1;
                exp_err = 1'b1;
                sb_done = 1;
            end
            hs_prev = 0;
            if (spikes_valid_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_vector: got valid after %0d handshakes want %0d", hs_n, NST);
                end else begin
                    chkv("spikes", spikes_o, sb_q[0]);
                    if (ip_ready_i) begin
                        void'(sb_q.pop_front());
                        hs_prev = 1;
                        hs_n++;
                    end
                end
            end
        end
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        ip_ready_i = 1'b1;
        @(negedge clk_i);
        chk("sample_tail", 32'(sample_o), 32'd0);
        chk("done_sticky", 32'(done_o), 32'd1);
        chkv("spikes_tail", spikes_o, fr);
    endtask

    int lat;

    initial begin
        vecs[0] = '{idx: 5'd25, data: 32'h0000_DEAD, exp_err: 1'b1, rnd: 1'b0};
        vecs[1] = '{idx: 5'd31, data: 32'h0000_1234, exp_err: 1'b1, rnd: 1'b1};
        vecs[2] = '{idx: 5'd0,  data: 32'h0000_0000, exp_err: 1'b0, rnd: 1'b0};
        vecs[3] = '{idx: 5'd7,  data: 32'h8000_0001, exp_err: 1'b0, rnd: 1'b1};
        vecs[4] = '{idx: 5'd24, data: 32'hFFFF_FFFF, exp_err: 1'b0, rnd: 1'b0};

        rst_ni = 1'b0; test_mode_i = 1'b0; reg_we_i = 1'b0; reg_widx_i = '0;
        reg_wdata_i = '0; start_i = 1'b0; ip_ready_i = 1'b0;
        clear_model();
        repeat (3) @(negedge clk_i);
        chkv("reset_spikes", spikes_o, '0);
        chk("reset_valid", 32'(spikes_valid_o), 32'd0);
        chk("reset_sample", 32'(sample_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;

        // Full frame, ready held high.
        for (int k = 0; k < NR; k++) wr(IW'(k), 32'hA5A5_0000 + 32'(k));
        run_inf(0, -1, 0, -1, -1, -1, 0, lat);
        chk("frame_word0", spikes_o[31:0], 32'hA5A5_0000);
        chk("frame_top16", 32'(spikes_o[783:768]), 32'h0000_0018);
        chk("latency", 32'(lat), 32'd29);

        // Table of single writes, each followed by an inference.
        test_mode_i = 1'b1;
        for (int v = 0; v < 5; v++) begin
            wr(vecs[v].idx, vecs[v].data);
            chk("table_err", 32'(err_o), 32'(vecs[v].exp_err));
            run_inf(vecs[v].rnd, -1, 0, -1, -1, -1, 0, lat);
        end
        test_mode_i = 1'b0;

        // Ten-cycle stall in DRIVE.
        run_inf(0, 3, 10, -1, -1, -1, 0, lat);
        chk("stall_latency", 32'(lat), 32'd39);

        // Write to word 3 while busy, then a start while busy.
        run_inf(0, -1, 0, 5, -1, -1, 0, lat);
        chk("err_after_bw", 32'(err_o), 32'd1);
        run_inf(1, -1, 0, -1, 2, -1, 0, lat);

        // Same-cycle start and write.
        wr(IW'(0), 32'h0);
        run_inf(0, -1, 0, -1, -1, -1, 1, lat);
        chk("same_cycle_old", spikes_o[31:0], 32'h0);
        run_inf(0, -1, 0, -1, -1, -1, 0, lat);
        chk("same_cycle_new", spikes_o[31:0], 32'h1);

        // Reset mid-inference, then a clean run of zero spikes.
        run_inf(0, -1, 0, -1, -1, 7, 0, lat);
        run_inf(0, -1, 0, -1, -1, -1, 0, lat);
        chkv("post_reset_zero", spikes_o, '0);
        chk("post_reset_latency", 32'(lat), 32'd29);

        // Write accepted on the first edge after reset release.
        rst_ni = 1'b0;
        @(negedge clk_i);
        clear_model();
        rst_ni = 1'b1;
        wr(IW'(1), 32'h5A5A_C3C3);
        run_inf(0, -1, 0, -1, -1, -1, 0, lat);
        chk("first_edge_write", spikes_o[63:32], 32'h5A5A_C3C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
